// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants and types for the HI/LO execute unit.
// Build option: HILO_FAST_MUL_EN selects a single-cycle multiplier (see hilo_unit).
package hilo_pkg;

  localparam int HILO_OP_W  = 9;

  // Bit positions inside the one-hot hilo_op vector from decode.
  localparam int HILO_MFHI  = 8;
  localparam int HILO_MFLO  = 7;
  localparam int HILO_MTHI  = 6;
  localparam int HILO_MTLO  = 5;
  localparam int HILO_MULT  = 4;
  localparam int HILO_MULTU = 3;
  localparam int HILO_DIV   = 2;
  localparam int HILO_DIVU  = 1;
  localparam int HILO_MUL   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } hilo_state_e;

  // Two's-complement magnitude of v when neg is set, v unchanged otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_unit_div_iter.sv
// div_iter: iterative engine shared by restoring division and shift-add
// multiplication. Works on magnitudes and applies sign fix-ups on the way out.
// Build option: HILO_FAST_MUL_EN (in hilo_unit) keeps multiplies off this path.
//
// state | meaning
// IDLE  | waiting for an accepted multi-cycle op
// BUSY  | one quotient / product bit per cycle, counter 0..DIV_CYCLES-1
// DONE  | result stable on o_hi/o_lo, consumed by hilo_unit this cycle
module div_iter
  import hilo_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_start,
  input  logic        i_is_mul,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output hilo_state_e o_state,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  hilo_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;     // partial remainder / product accumulator
  logic [31:0]      r_lo;     // dividend->quotient / multiplier->product low
  logic [31:0]      r_b;      // divisor / multiplicand magnitude
  logic             r_is_mul;
  logic             r_neg_q;  // negate quotient, or whole product for mul
  logic             r_neg_r;  // negate remainder (dividend sign)

  logic        w_a_neg;
  logic        w_b_neg;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;

  assign w_a_neg = i_signed & i_a[31];
  assign w_b_neg = i_signed & i_b[31];

  // Multiply step: conditional add of the multiplicand, then shift right.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  assign w_shift = {r_hi, r_lo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift - {1'b0, r_b};

  // FSM, counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_hi     <= '0;
            r_lo     <= mag32(i_a, w_a_neg);
            r_b      <= mag32(i_b, w_b_neg);
            r_is_mul <= i_is_mul;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (r_is_mul) begin
            r_hi <= w_sum[32:1];
            r_lo <= {w_sum[0], r_lo[31:1]};
          end else begin
            r_hi <= w_ge ? w_diff[31:0] : w_shift[31:0];
            r_lo <= {r_lo[30:0], w_ge};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sign fix-up of the finished magnitude result.
  always_comb begin
    w_prod     = {r_hi, r_lo};
    w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
    if (r_is_mul) begin
      o_hi = w_prod_fix[63:32];
      o_lo = w_prod_fix[31:0];
    end else begin
      o_hi = mag32(r_hi, r_neg_r);
      o_lo = mag32(r_lo, r_neg_q);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: execute-stage HI/LO unit. Owns HI/LO, the mfhi/mflo/mul read mux
// and write control; multi-cycle work is delegated to div_iter.
// Build option: HILO_FAST_MUL_EN -> mult/multu/mul use a single-cycle 33x33
// signed multiplier; otherwise they share the iterative engine with div.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [HILO_OP_W-1:0] hilo_op,
  input  logic [31:0]          src1,
  input  logic [31:0]          src2,
  output logic                 stallreq,
  output logic [31:0]          hilo_rdata,
  output logic [31:0]          hi_o,
  output logic [31:0]          lo_o
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_valid;
  logic        w_is_div;
  logic        w_is_mulgrp;
  logic        w_signed;
  logic        w_multi;
  logic        w_iter_mul;
  logic        w_iter_wr;
  logic        w_start;
  hilo_state_e w_state;
  logic [31:0] w_iter_hi;
  logic [31:0] w_iter_lo;

  assign w_valid     = en & ~flush;
  assign w_is_div    = hilo_op[HILO_DIV] | hilo_op[HILO_DIVU];
  assign w_is_mulgrp = hilo_op[HILO_MULT] | hilo_op[HILO_MULTU] | hilo_op[HILO_MUL];
  assign w_signed    = hilo_op[HILO_DIV] | hilo_op[HILO_MULT] | hilo_op[HILO_MUL];

`ifdef HILO_FAST_MUL_EN
  logic signed [32:0] w_ma;
  logic signed [32:0] w_mb;
  logic signed [63:0] w_fast_prod;

  // Sign-extend for signed ops, zero-extend for multu; 33 bits covers both.
  assign w_ma        = {w_signed & src1[31], src1};
  assign w_mb        = {w_signed & src2[31], src2};
  assign w_fast_prod = w_ma * w_mb;

  assign w_multi    = w_is_div;
  assign w_iter_mul = 1'b0;
  assign w_iter_wr  = w_is_div;
`else
  assign w_multi    = w_is_div | w_is_mulgrp;
  assign w_iter_mul = w_is_mulgrp;
  assign w_iter_wr  = w_is_div | hilo_op[HILO_MULT] | hilo_op[HILO_MULTU];
`endif

  // DONE is not IDLE, so the instruction still sitting in EX is not re-accepted.
  assign w_start = w_valid & w_multi & (w_state == IDLE);

  // Stall covers the accept cycle plus every BUSY cycle; flush/rst drop it at once.
  assign stallreq = ~rst & ~flush &
                    (((w_state == IDLE) & en & w_multi) | (w_state == BUSY));

  div_iter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (flush),
    .i_start  (w_start),
    .i_is_mul (w_iter_mul),
    .i_signed (w_signed),
    .i_a      (src1),
    .i_b      (src2),
    .o_state  (w_state),
    .o_hi     (w_iter_hi),
    .o_lo     (w_iter_lo)
  );

  // Architectural HI/LO updates; every write is gated by a valid, unflushed op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_valid) begin
      if (hilo_op[HILO_MTHI]) r_hi <= src1;
      if (hilo_op[HILO_MTLO]) r_lo <= src1;
`ifdef HILO_FAST_MUL_EN
      if (hilo_op[HILO_MULT] | hilo_op[HILO_MULTU]) begin
        r_hi <= w_fast_prod[63:32];
        r_lo <= w_fast_prod[31:0];
      end
`endif
      if ((w_state == DONE) && w_iter_wr) begin
        r_hi <= w_iter_hi;
        r_lo <= w_iter_lo;
      end
    end
  end

  // Read mux: mfhi/mflo see the registers, mul sees the low product word.
  always_comb begin
    hilo_rdata = '0;
    if (en) begin
      if (hilo_op[HILO_MFHI]) begin
        hilo_rdata = r_hi;
      end else if (hilo_op[HILO_MFLO]) begin
        hilo_rdata = r_lo;
      end else if (hilo_op[HILO_MUL]) begin
`ifdef HILO_FAST_MUL_EN
        hilo_rdata = w_fast_prod[31:0];
`else
        if (w_state == DONE) hilo_rdata = w_iter_lo;
`endif
      end
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
